// File: rtl/sram_if.sv
// Read/write port bundle for the lane-masked SRAM.
// The master drives addresses, write data and lane mask; the slave returns read data.
interface sram_if #(
  parameter int WIDTH    = 32,
  parameter int LOGDEPTH = 9,
  parameter int WORDSIZE = 8
);
  localparam int LANES = WIDTH / WORDSIZE;

  logic [LOGDEPTH-1:0] readAddr;
  logic [WIDTH-1:0]    readData;
  logic [LOGDEPTH-1:0] writeAddr;
  logic [WIDTH-1:0]    writeData;
  logic [LANES-1:0]    writeEnable;

  modport master (
    output readAddr,
    output writeAddr,
    output writeData,
    output writeEnable,
    input  readData
  );

  modport slave (
    input  readAddr,
    input  writeAddr,
    input  writeData,
    input  writeEnable,
    output readData
  );
endinterface

// File: rtl/sram.sv
// Single-clock, read-first SRAM with per-lane write mask and a DELAY-deep read pipeline.
// Reset clears only the read path; the array keeps its contents and writes are blocked.
module sram #(
  parameter int WIDTH    = 32,
  parameter int LOGDEPTH = 9,
  parameter int WORDSIZE = 8,
  parameter int DELAY    = 0
) (
  input logic   clk,
  input logic   reset,
  sram_if.slave bus
);
  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int LANES = WIDTH / WORDSIZE;

  if (WIDTH % WORDSIZE != 0) begin : g_bad_lanes
    $error("sram: WIDTH (%0d) must be a multiple of WORDSIZE (%0d)", WIDTH, WORDSIZE);
  end

  // Rows start at zero; there is no reset path into the array.
  logic [WIDTH-1:0] r_mem  [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] r_pipe [DELAY+1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.writeEnable[k]) begin
          r_mem[bus.writeAddr][k*WORDSIZE +: WORDSIZE] <= bus.writeData[k*WORDSIZE +: WORDSIZE];
        end
      end
    end
  end

  // Stage 0 samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= DELAY; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0] <= r_mem[bus.readAddr];
      for (int s = 1; s <= DELAY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign bus.readData = r_pipe[DELAY];
endmodule

// File: tb/tb_sram.sv
// Directed bench for sram: wide lane-masked, single-lane and pipelined configurations.
module tb_sram;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;

  sram_if #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64)) bus_a ();
  sram_if #(.WIDTH(52),  .LOGDEPTH(9), .WORDSIZE(52)) bus_b ();
  sram_if #(.WIDTH(32),  .LOGDEPTH(4), .WORDSIZE(8))  bus_c ();

  sram #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64), .DELAY(0)) u_sram_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  sram #(.WIDTH(52),  .LOGDEPTH(9), .WORDSIZE(52), .DELAY(0)) u_sram_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));
  sram #(.WIDTH(32),  .LOGDEPTH(4), .WORDSIZE(8),  .DELAY(2)) u_sram_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] all_a, all_5, all_f, masked;

  initial begin
    n_tests  = 0;
    n_failed = 0;
    all_a  = {8{64'hAAAA_AAAA_AAAA_AAAA}};
    all_5  = {8{64'h5555_5555_5555_5555}};
    all_f  = {512{1'b1}};
    masked = all_a;
    masked[128 +: 64] = 64'h5555_5555_5555_5555;

    reset = 1'b1;
    bus_a.readAddr = '0; bus_a.writeAddr = '0; bus_a.writeData = '0; bus_a.writeEnable = '0;
    bus_b.readAddr = '0; bus_b.writeAddr = '0; bus_b.writeData = '0; bus_b.writeEnable = '0;
    bus_c.readAddr = '0; bus_c.writeAddr = '0; bus_c.writeData = '0; bus_c.writeEnable = '0;
    tick(); tick();
    check("rst_a", bus_a.readData, 512'd0);
    check("rst_b", 512'(bus_b.readData), 512'd0);
    check("rst_c", 512'(bus_c.readData), 512'd0);
    reset = 1'b0;

    // Full-row write, read-first on the write edge
    bus_a.writeAddr = 9'd5; bus_a.writeData = all_a; bus_a.writeEnable = 8'hFF; bus_a.readAddr = 9'd5;
    tick();
    check("full_row_same_edge", bus_a.readData, 512'd0);
    bus_a.writeEnable = 8'h00;
    tick();
    check("full_row", bus_a.readData, all_a);

    // Lane mask: only lane 2 takes the new data
    bus_a.writeData = all_5; bus_a.writeEnable = 8'h04;
    tick();
    check("lane_mask_same_edge", bus_a.readData, all_a);
    bus_a.writeEnable = 8'h00;
    tick();
    check("lane_mask", bus_a.readData, masked);
    tick();
    check("hold_const_addr", bus_a.readData, masked);

    // Read-first collision on row 3
    bus_a.writeAddr = 9'd3; bus_a.writeData = 512'h1; bus_a.writeEnable = 8'hFF;
    tick();
    bus_a.writeData = 512'h2; bus_a.readAddr = 9'd3;
    tick();
    check("collision_old", bus_a.readData, 512'h1);
    bus_a.writeEnable = 8'h00;
    tick();
    check("collision_new", bus_a.readData, 512'h2);

    // Simultaneous read and write to different rows, then top address
    bus_a.readAddr = 9'd5; bus_a.writeAddr = 9'd511; bus_a.writeData = all_5; bus_a.writeEnable = 8'hFF;
    tick();
    check("rw_diff_rows", bus_a.readData, masked);
    bus_a.writeEnable = 8'h00; bus_a.readAddr = 9'd511;
    tick();
    check("top_addr_a", bus_a.readData, all_5);

    // Single-lane configuration
    bus_b.writeAddr = 9'd511; bus_b.writeData = 52'h12345; bus_b.writeEnable = 1'b1;
    tick();
    bus_b.writeEnable = 1'b0; bus_b.readAddr = 9'd511;
    tick();
    check("single_lane_511", 512'(bus_b.readData), 512'h12345);
    bus_b.readAddr = 9'd0;
    tick();
    check("single_lane_row0", 512'(bus_b.readData), 512'd0);

    // Pipelined reads, DELAY = 2
    for (int r = 1; r <= 3; r++) begin
      bus_c.writeAddr = 4'(r); bus_c.writeData = 32'hC0DE_0000 + 32'(r); bus_c.writeEnable = 4'hF;
      tick();
    end
    bus_c.writeEnable = 4'h0;
    bus_c.readAddr = 4'd1;
    tick();
    bus_c.readAddr = 4'd2;
    tick();
    check("pipe_not_yet", 512'(bus_c.readData), 512'd0);
    bus_c.readAddr = 4'd3;
    tick();
    check("pipe_first", 512'(bus_c.readData), 512'hC0DE_0001);
    tick();
    check("pipe_second", 512'(bus_c.readData), 512'hC0DE_0002);
    tick();
    check("pipe_third", 512'(bus_c.readData), 512'hC0DE_0003);

    // Reset blocks writes and clears the read path, array survives
    bus_a.writeAddr = 9'd7; bus_a.writeData = all_f; bus_a.writeEnable = 8'hFF;
    tick();
    bus_a.readAddr = 9'd7; bus_a.writeData = 512'd0;
    bus_c.readAddr = 4'd2;
    reset = 1'b1;
    tick();
    check("rst_hold_a_1", bus_a.readData, 512'd0);
    check("rst_hold_c", 512'(bus_c.readData), 512'd0);
    tick();
    check("rst_hold_a_2", bus_a.readData, 512'd0);
    reset = 1'b0;
    bus_a.writeEnable = 8'h00;
    tick();
    check("rst_array_kept", bus_a.readData, all_f);
    check("rst_pipe_c_e1", 512'(bus_c.readData), 512'd0);
    tick();
    check("rst_pipe_c_e2", 512'(bus_c.readData), 512'd0);
    tick();
    check("rst_pipe_c_e3", 512'(bus_c.readData), 512'hC0DE_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule

// File: doc/sram.md
SRAM -- requirements
Module: sram

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per row, i.e. read/write data width.
REQ-002 SHALL have parameter LOGDEPTH, default 9: log2 of the row count; depth = 2^LOGDEPTH.
REQ-003 SHALL have parameter WORDSIZE, default 8: bits per write-enable lane; lanes = WIDTH/WORDSIZE.
REQ-004 SHALL have parameter DELAY, default 0: extra read pipeline stages beyond the base 1-cycle latency.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port readAddr, input, LOGDEPTH bits: read row index.
REQ-008 SHALL have port readData, output, WIDTH bits: registered read data.
REQ-009 SHALL have port writeAddr, input, LOGDEPTH bits: write row index.
REQ-010 SHALL have port writeData, input, WIDTH bits: write data.
REQ-011 SHALL have port writeEnable, input, WIDTH/WORDSIZE bits: per-lane write mask; bit k covers writeData[k*WORDSIZE +: WORDSIZE].

Function
REQ-012 SHALL store 2^LOGDEPTH rows of WIDTH bits each.
REQ-013 SHALL flag an elaboration error when WIDTH is not an integer multiple of WORDSIZE; WIDTH == WORDSIZE, a single lane, is legal.
REQ-014 SHALL, on each rising edge with reset low, write lane k of row writeAddr from writeData for every set writeEnable[k]; clear lanes keep their contents.
REQ-015 SHALL treat writeEnable == 0 as no write; any lane subset is legal.
REQ-016 SHALL sample readAddr on every rising edge; there is no read enable, so a read occurs every cycle.
REQ-017 SHALL present the row addressed at edge N on readData after edge N+DELAY, where DELAY=0 gives data one cycle after the address.
REQ-018 SHALL hold readData between updates; with a constant readAddr and no writes to that row, readData stays constant.
REQ-019 SHALL, when readAddr == writeAddr at the same edge, return the pre-write row contents (read-first); the new data is visible from the next read onward.
REQ-020 SHALL allow simultaneous reads and writes to different rows with no interaction.
REQ-021 SHALL keep read pipeline stages independent, so back-to-back reads to different addresses each emerge in order, one per cycle.
REQ-022 SHALL contain only row storage, lane-masked write logic, read register(s) and the DELAY pipeline; there is no handshake and no other state machine.
REQ-023 SHALL use the full LOGDEPTH address with no wrap logic; address 2^LOGDEPTH-1 is valid.

Reset
REQ-024 SHALL clear readData and every read pipeline stage to 0 at a rising edge while reset is high.
REQ-025 SHALL ignore writeEnable while reset is high, so no array write occurs.
REQ-026 SHALL leave array contents unchanged by reset.
REQ-027 SHALL initialise every row to 0 at simulation time zero.
REQ-028 SHALL restart the read pipeline on the first edge after reset deasserts, which samples readAddr as normal; an in-flight read cut by reset is discarded.

Verification
REQ-029 Full-row write: WIDTH=512, WORDSIZE=64, LOGDEPTH=9; write 0xAA..AA to row 5 with writeEnable=8'hFF, then hold readAddr=5 -> readData=0xAA..AA one cycle later.
REQ-030 Lane mask: row 5 holds 0xAA..AA; write 0x55..55 with writeEnable=8'h04 -> read gives lane 2 = 0x5555555555555555 and all other lanes = 0xAAAAAAAAAAAAAAAA.
REQ-031 Read-first collision: row 3 = 0x1, then write 0x2 to row 3 while reading row 3 in the same cycle -> readData=0x1 after that edge, 0x2 after the next edge.
REQ-032 Single-lane config: WIDTH=WORDSIZE=52, LOGDEPTH=9; write tag 0x12345 to row 511 with writeEnable=1 -> reading row 511 returns 0x12345 and row 0 returns 0.
REQ-033 Reset: fill row 7 with 0xFF..FF, assert reset for 2 cycles with writeEnable=all-ones and writeData=0 on row 7 -> readData=0 during reset, row 7 reads 0xFF..FF after deassertion.
REQ-034 Pipelined reads: DELAY=2; issue readAddr 1,2,3 on consecutive edges -> their contents appear on three consecutive cycles, starting 3 cycles after the first address.
